hht_mem_responder: RTL

- Memory-side responder for the HHT `control` block's two read ports.
- Port 1 serves the matrix-column window. Port 2 serves the v-values window. Any address outside a port's window returns a fixed miss pattern.
- Memories are filled by a streaming load interface. `control` then reads them and may write updated column words back.
- Replaces the bench-side combinational case tables with a synthesizable, registered memory.

---
 rtl/hht_mem_responder_pkg.sv | 24 ++
 rtl/hht_mem_responder_if.sv | 29 ++
 rtl/hht_mem_responder_ram.sv | 23 ++
 rtl/hht_mem_responder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/hht_mem_responder_pkg.sv
// Shared widths, default window geometry, load FSM states and the
// address-window helper used by the HHT memory responder.
package hht_mem_pkg;

  localparam int unsigned DW             = 32;
  localparam int unsigned DEF_COL_BASE   = 340;
  localparam int unsigned DEF_COL_SIZE   = 102;
  localparam int unsigned DEF_V_BASE     = 2;
  localparam int unsigned DEF_V_SIZE     = 32;
  localparam int unsigned DEF_MISS_VALUE = 99999;

  typedef enum logic [1:0] {
    LOAD_COL,
    LOAD_V,
    READY
  } ld_state_t;

  // Full-width unsigned compare; the subtraction form avoids base+size overflow.
  function automatic logic in_window(logic [DW-1:0] addr, logic [DW-1:0] base,
                                     logic [DW-1:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/hht_mem_responder_if.sv
// Load stream, two read ports and the column write-back port between
// the HHT control block (master) and the memory responder (slave).
interface hht_mem_responder_if;
  import hht_mem_pkg::*;

  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          mem_ready;
  logic [DW-1:0] addr1;
  logic [DW-1:0] dataIn1;
  logic [DW-1:0] addr2;
  logic [DW-1:0] dataIn2;
  logic          WR;
  logic [DW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;

  modport master (
    output ld_valid, ld_data, addr1, addr2, WR, wr_addr, wr_data,
    input  ld_ready, mem_ready, dataIn1, dataIn2, wr_err
  );

  modport slave (
    input  ld_valid, ld_data, addr1, addr2, WR, wr_addr, wr_data,
    output ld_ready, mem_ready, dataIn1, dataIn2, wr_err
  );

endinterface

// File: rtl/hht_mem_responder_ram.sv
// Single-clock region RAM: one write port, one registered read port.
// A read and write to the same word in one cycle returns the old word.
module hht_region_ram #(
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned DW    = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hht_mem_responder.sv
// Memory-side responder for HHT control: streamed load of the column and
// v windows, registered reads with miss pattern, column write-back.
//
//   state    | meaning
//   LOAD_COL | accepting column words into col[ptr]
//   LOAD_V   | accepting v words into v[ptr]
//   READY    | loaded; reads valid, write-back allowed, load stream closed
module hht_mem_responder
  import hht_mem_pkg::*;
#(
  parameter int unsigned   COL_BASE   = DEF_COL_BASE,
  parameter int unsigned   COL_SIZE   = DEF_COL_SIZE,
  parameter int unsigned   V_BASE     = DEF_V_BASE,
  parameter int unsigned   V_SIZE     = DEF_V_SIZE,
  parameter logic [DW-1:0] MISS_VALUE = DW'(DEF_MISS_VALUE)
) (
  input logic                Clk,
  input logic                Rst,
  hht_mem_responder_if.slave bus
);

  localparam int unsigned CAW = $clog2(COL_SIZE);
  localparam int unsigned VAW = $clog2(V_SIZE);
  localparam int unsigned PW  = (CAW > VAW) ? CAW : VAW;

  ld_state_t      state, state_nxt;
  logic [PW-1:0]  ptr, ptr_nxt;
  logic           ld_fire;
  logic           wb_hit;
  logic           col_we, v_we;
  logic [CAW-1:0] col_waddr, col_raddr;
  logic [DW-1:0]  col_wdata, col_rdata, v_rdata;
  logic [VAW-1:0] v_raddr;
  logic           rd_hit1, rd_hit2, hit1_q, hit2_q;
  logic           wr_err_q;

  assign bus.mem_ready = (state == READY);
  assign bus.ld_ready  = (state != READY);
  assign ld_fire       = bus.ld_valid && bus.ld_ready;
  assign wb_hit        = in_window(bus.wr_addr, DW'(COL_BASE), DW'(COL_SIZE));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= LOAD_COL;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    col_we    = 1'b0;
    v_we      = 1'b0;
    col_waddr = ptr[CAW-1:0];
    col_wdata = bus.ld_data;
    case (state)
      LOAD_COL: if (ld_fire) begin
        col_we = 1'b1;
        if (ptr == PW'(COL_SIZE - 1)) begin
          ptr_nxt   = '0;
          state_nxt = LOAD_V;
        end else begin
          ptr_nxt = ptr + PW'(1);
        end
      end
      LOAD_V: if (ld_fire) begin
        v_we = 1'b1;
        if (ptr == PW'(V_SIZE - 1)) begin
          ptr_nxt   = '0;
          state_nxt = READY;
        end else begin
          ptr_nxt = ptr + PW'(1);
        end
      end
      READY: if (bus.WR && wb_hit) begin
        col_we    = 1'b1;
        col_waddr = CAW'(bus.wr_addr - DW'(COL_BASE));
        col_wdata = bus.wr_data;
      end
      default: state_nxt = LOAD_COL;
    endcase
  end

  // Read indices are forced to zero on a miss so the RAM never sees an out-of-range index.
  assign rd_hit1   = bus.mem_ready && in_window(bus.addr1, DW'(COL_BASE), DW'(COL_SIZE));
  assign rd_hit2   = bus.mem_ready && in_window(bus.addr2, DW'(V_BASE), DW'(V_SIZE));
  assign col_raddr = rd_hit1 ? CAW'(bus.addr1 - DW'(COL_BASE)) : '0;
  assign v_raddr   = rd_hit2 ? VAW'(bus.addr2 - DW'(V_BASE)) : '0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      hit1_q <= rd_hit1;
      hit2_q <= rd_hit2;
      if (bus.WR && !(bus.mem_ready && wb_hit)) wr_err_q <= 1'b1;
    end
  end

  assign bus.dataIn1 = hit1_q ? col_rdata : MISS_VALUE;
  assign bus.dataIn2 = hit2_q ? v_rdata : MISS_VALUE;
  assign bus.wr_err  = wr_err_q;

  hht_region_ram #(.DEPTH(COL_SIZE), .DW(DW)) u_col_ram (
    .clk   (Clk),
    .we    (col_we && !Rst),
    .waddr (col_waddr),
    .wdata (col_wdata),
    .raddr (col_raddr),
    .rdata (col_rdata)
  );

  hht_region_ram #(.DEPTH(V_SIZE), .DW(DW)) u_v_ram (
    .clk   (Clk),
    .we    (v_we && !Rst),
    .waddr (ptr[VAW-1:0]),
    .wdata (bus.ld_data),
    .raddr (v_raddr),
    .rdata (v_rdata)
  );

endmodule
